multi_alarm_ctrl: RTL and testbench
===================================

MULTI_ALARM_CTRL -- requirements
Module: multi_alarm_ctrl

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of independent alarm channels, range 1..16.
REQ-002 Parameter RING_SEC, default 60: ticks a channel rings before auto-off, range 1..255.
REQ-003 Parameter SNOOZE_MIN, default 5: snooze length in minutes, range 1..30.
REQ-004 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 tick  in  1  one-cycle 1 Hz strobe; all time-based counting advances only on tick.
REQ-007 cur_hr24 / cur_min / cur_sec  in  5/6/6  current time, 24-hour, from the clock block.
REQ-008 wr_en  in  1  programming strobe.
REQ-009 wr_idx  in  IDXW = max(1,clog2(NUM_ALARMS))  target channel.
REQ-010 wr_hr / wr_min / wr_arm  in  5/6/1  alarm time (24-hour) and arm bit.
REQ-011 snooze / dismiss  in  1/1  one-cycle user pulses, act on all ringing channels.
REQ-012 ringing  out  NUM_ALARMS  per-channel ringing flags, registered.
REQ-013 buzzer  out  1  OR of ringing.
REQ-014 active_idx  out  IDXW  lowest-index ringing channel; 0 when none ring.

Function
REQ-015 Each channel holds hr, min, arm and a state: IDLE, RINGING, SNOOZED.
REQ-016 IDLE->RINGING when tick=1, arm=1, cur_hr24==hr, cur_min==min, cur_sec==0; ringing visible the cycle after the tick.
REQ-017 RINGING: ring counter loads RING_SEC on entry, decrements per tick; at 0 -> IDLE (auto-off, arm stays 1).
REQ-018 RINGING + snooze -> SNOOZED; snooze counter loads SNOOZE_MIN*60 (12-bit), decrements per tick.
REQ-019 SNOOZED counter reaching 0 -> RINGING with ring counter reloaded; snooze count unlimited.
REQ-020 dismiss -> IDLE from RINGING or SNOOZED.
REQ-021 Priority per cycle: rst > wr_en to that channel > dismiss > snooze > tick-driven transitions.
REQ-022 wr_en loads hr/min/arm next cycle and forces that channel IDLE, clearing counters; other channels unaffected.
REQ-023 wr_hr > 23 or wr_min > 59: write ignored entirely; wr_idx >= NUM_ALARMS: ignored.
REQ-024 Alarm fires once per match minute; re-trigger blocked while cur_sec != 0, so dismiss within the match minute does not re-ring.
REQ-025 Multiple channels matching on one tick ring together; active_idx reports the lowest.
REQ-026 Disarmed (arm=0) channel never triggers; snooze/dismiss with no channel ringing or snoozed: no effect.

Reset
REQ-027 rst: all channels IDLE, hr=0, min=0, arm=0, counters 0; ringing=0, buzzer=0, active_idx=0, effective the cycle after rst is sampled.
REQ-028 rst mid-ring or mid-snooze returns to reset state immediately; no pending event survives.

Configuration
REQ-029 Macro ALARM_SNOOZE_EN defined: SNOOZED state, snooze counter and snooze input behaviour per REQ-018/019.
REQ-030 ALARM_SNOOZE_EN undefined: snooze input ignored, SNOOZED state and snooze counters not built; all other behaviour identical.

Structure
REQ-031 Package alarm_pkg holds the channel state enum, counter widths, and constants SEC_PER_MIN=60, MAX_HR24=23, MAX_MIN=59.
REQ-032 Sub-module alarm_channel implements one channel's registers and FSM; top instantiates NUM_ALARMS copies plus priority encoder and OR.

Verification
REQ-033 Program ch0 07:30 armed; drive time 07:29:59 then tick at 07:30:00 -> ringing[0]=1 next cycle, buzzer=1, active_idx=0.
REQ-034 Ch0 ringing, no input, RING_SEC=60 -> ringing[0] drops after 60th tick; no re-trigger at 07:30:xx.
REQ-035 Ch1 ringing, snooze pulse -> ringing[1]=0; after SNOOZE_MIN*60=300 ticks ringing[1]=1 again; dismiss -> IDLE.
REQ-036 Ch1 and ch3 both at 06:00, tick at 06:00:00 -> ringing=4'b1010, active_idx=1; dismiss -> ringing=0.
REQ-037 Ch2 ringing, wr_en idx=2 hr=25 -> ignored, still ringing; then valid write -> ch2 IDLE next cycle.
REQ-038 rst asserted while ch0 SNOOZED -> all outputs 0, arm=0; with ALARM_SNOOZE_EN undefined snooze pulse leaves ringing unchanged.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_e;

  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned MAX_HR24    = 23;
  localparam int unsigned MAX_MIN     = 59;

  localparam int unsigned HR_W      = 5;
  localparam int unsigned MIN_W     = 6;
  localparam int unsigned SEC_W     = 6;
  localparam int unsigned RING_CW   = 8;
  localparam int unsigned SNOOZE_CW = 12;

  // Channel index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// Alarm programming bus: one write strobe carrying target channel, time and arm bit.
interface multi_alarm_ctrl_if
  import alarm_pkg::*;
#(
  parameter int unsigned IDXW = 2
) ();

  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [HR_W-1:0]  wr_hr;
  logic [MIN_W-1:0] wr_min;
  logic             wr_arm;

  modport master (output wr_en, wr_idx, wr_hr, wr_min, wr_arm);
  modport slave  (input  wr_en, wr_idx, wr_hr, wr_min, wr_arm);

endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: programmed time, arm bit, ring/snooze counters and FSM.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [HR_W-1:0]  cur_hr24,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic             wr_sel,
  input  logic [HR_W-1:0]  wr_hr,
  input  logic [MIN_W-1:0] wr_min,
  input  logic             wr_arm,
  input  logic             snooze,
  input  logic             dismiss,
  output logic             ring,
  output logic             ring_nxt_c
);

  localparam logic [RING_CW-1:0] RING_LOAD = RING_CW'(RING_SEC);

  alarm_state_e       state, state_nxt;
  logic [HR_W-1:0]    al_hr, al_hr_nxt;
  logic [MIN_W-1:0]   al_min, al_min_nxt;
  logic               arm, arm_nxt;
  logic [RING_CW-1:0] ring_cnt, ring_cnt_nxt;
  logic               match;

`ifdef ALARM_SNOOZE_EN
  localparam logic [SNOOZE_CW-1:0] SNOOZE_LOAD = SNOOZE_CW'(SNOOZE_MIN * SEC_PER_MIN);
  logic [SNOOZE_CW-1:0] snz_cnt, snz_cnt_nxt;
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ (SNOOZE_MIN == 0);
`endif

  // Trigger condition: armed and exactly at second zero of the programmed minute.
  assign match = arm && (cur_hr24 == al_hr) && (cur_min == al_min) && (cur_sec == '0);

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      al_hr    <= '0;
      al_min   <= '0;
      arm      <= 1'b0;
      ring_cnt <= '0;
      ring     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      al_hr    <= al_hr_nxt;
      al_min   <= al_min_nxt;
      arm      <= arm_nxt;
      ring_cnt <= ring_cnt_nxt;
      ring     <= ring_nxt_c;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= snz_cnt_nxt;
`endif
    end
  end

  // Next state: write > dismiss > snooze > tick-driven transitions.
  always_comb begin
    state_nxt    = state;
    al_hr_nxt    = al_hr;
    al_min_nxt   = al_min;
    arm_nxt      = arm;
    ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_nxt  = snz_cnt;
`endif
    if (wr_sel) begin
      al_hr_nxt    = wr_hr;
      al_min_nxt   = wr_min;
      arm_nxt      = wr_arm;
      state_nxt    = ST_IDLE;
      ring_cnt_nxt = '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_nxt  = '0;
`endif
    end else if (dismiss && (state != ST_IDLE)) begin
      state_nxt    = ST_IDLE;
      ring_cnt_nxt = '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_nxt  = '0;
    end else if (snooze && (state == ST_RINGING)) begin
      state_nxt    = ST_SNOOZED;
      ring_cnt_nxt = '0;
      snz_cnt_nxt  = SNOOZE_LOAD;
`endif
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            state_nxt    = ST_RINGING;
            ring_cnt_nxt = RING_LOAD;
          end
        end
        ST_RINGING: begin
          if (ring_cnt <= RING_CW'(1)) begin
            state_nxt    = ST_IDLE;
            ring_cnt_nxt = '0;
          end else begin
            ring_cnt_nxt = ring_cnt - RING_CW'(1);
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZED: begin
          if (snz_cnt <= SNOOZE_CW'(1)) begin
            state_nxt    = ST_RINGING;
            ring_cnt_nxt = RING_LOAD;
            snz_cnt_nxt  = '0;
          end else begin
            snz_cnt_nxt  = snz_cnt - SNOOZE_CW'(1);
          end
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode of the next state, registered as ring.
  always_comb begin
    ring_nxt_c = (state_nxt == ST_RINGING);
  end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm controller: NUM_ALARMS channels, buzzer OR and lowest-index encoder.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module multi_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  localparam int unsigned IDXW      = idx_width(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [HR_W-1:0]       cur_hr24,
  input  logic [MIN_W-1:0]      cur_min,
  input  logic [SEC_W-1:0]      cur_sec,
  multi_alarm_ctrl_if.slave     bus,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  buzzer,
  output logic [IDXW-1:0]       active_idx
);

  logic                  wr_ok;
  logic [NUM_ALARMS-1:0] ring_nxt;
  logic [IDXW-1:0]       active_nxt;

  // Writes with an out-of-range time or channel index are dropped.
  assign wr_ok = bus.wr_en
              && (32'(bus.wr_hr)  <= MAX_HR24)
              && (32'(bus.wr_min) <= MAX_MIN)
              && (32'(bus.wr_idx) <  NUM_ALARMS);

  for (genvar g = 0; g < int'(NUM_ALARMS); g++) begin : g_ch
    alarm_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .cur_hr24   (cur_hr24),
      .cur_min    (cur_min),
      .cur_sec    (cur_sec),
      .wr_sel     (wr_ok && (32'(bus.wr_idx) == 32'(g))),
      .wr_hr      (bus.wr_hr),
      .wr_min     (bus.wr_min),
      .wr_arm     (bus.wr_arm),
      .snooze     (snooze),
      .dismiss    (dismiss),
      .ring       (ringing[g]),
      .ring_nxt_c (ring_nxt[g])
    );
  end

  // Lowest-index ringing channel, taken from next-state so it aligns with ringing.
  always_comb begin
    active_nxt = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (ring_nxt[i]) active_nxt = IDXW'(i);
    end
  end

  // Registered summary outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      buzzer     <= 1'b0;
      active_idx <= '0;
    end else begin
      buzzer     <= |ring_nxt;
      active_idx <= active_nxt;
    end
  end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Self-checking bench for multi_alarm_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the alarm rules.
module tb_multi_alarm_ctrl;
  import alarm_pkg::*;

  localparam int unsigned NA = 4;
  localparam int unsigned RS = 60;
  localparam int unsigned SM = 5;
  localparam int unsigned IW = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, tick, snooze, dismiss;
  logic [4:0]    cur_hr24;
  logic [5:0]    cur_min, cur_sec;
  logic [NA-1:0] ringing;
  logic          buzzer;
  logic [IW-1:0] active_idx;

  multi_alarm_ctrl_if #(.IDXW(IW)) bus ();

  multi_alarm_ctrl #(.NUM_ALARMS(NA), .RING_SEC(RS), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cur_hr24(cur_hr24), .cur_min(cur_min),
    .cur_sec(cur_sec), .bus(bus), .snooze(snooze), .dismiss(dismiss),
    .ringing(ringing), .buzzer(buzzer), .active_idx(active_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tod   = 0;

  // Model: per channel alarm time, arm, mode (0 quiet, 1 ringing, 2 snoozed), ticks left.
  int m_hr [NA];
  int m_min[NA];
  bit m_arm[NA];
  int m_mode[NA];
  int m_left[NA];

  function automatic void set_time();
    cur_hr24 = 5'(tod / 3600);
    cur_min  = 6'((tod / 60) % 60);
    cur_sec  = 6'(tod % 60);
  endfunction

  function automatic logic [NA-1:0] exp_ring();
    logic [NA-1:0] v;
    v = '0;
    for (int i = 0; i < NA; i++) v[i] = (m_mode[i] == 1);
    return v;
  endfunction

  function automatic logic [IW-1:0] exp_idx();
    for (int i = 0; i < NA; i++) if (m_mode[i] == 1) return IW'(i);
    return '0;
  endfunction

  // Apply the alarm rules to the model for the inputs currently driven.
  task automatic model_step();
    bit hit;
    int now_h, now_m, now_s;
    now_h = tod / 3600; now_m = (tod / 60) % 60; now_s = tod % 60;
    for (int c = 0; c < NA; c++) begin
      hit = bus.wr_en && (int'(bus.wr_hr) <= 23) && (int'(bus.wr_min) <= 59)
            && (int'(bus.wr_idx) == c);
      if (rst) begin
        m_hr[c] = 0; m_min[c] = 0; m_arm[c] = 0; m_mode[c] = 0; m_left[c] = 0;
      end else if (hit) begin
        m_hr[c] = int'(bus.wr_hr); m_min[c] = int'(bus.wr_min); m_arm[c] = bus.wr_arm;
        m_mode[c] = 0; m_left[c] = 0;
      end else if (dismiss && m_mode[c] != 0) begin
        m_mode[c] = 0;
      end else if (SNZ && snooze && m_mode[c] == 1) begin
        m_mode[c] = 2; m_left[c] = SM * 60;
      end else if (tick) begin
        if (m_mode[c] == 0) begin
          if (m_arm[c] && now_h == m_hr[c] && now_m == m_min[c] && now_s == 0) begin
            m_mode[c] = 1; m_left[c] = RS;
          end
        end else begin
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            if (m_mode[c] == 1) m_mode[c] = 0;
            else begin m_mode[c] = 1; m_left[c] = RS; end
          end
        end
      end
    end
  endtask

  task automatic cyc();
    set_time();
    model_step();
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; snooze = 1'b0; dismiss = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc();
    tod = (tod + 1) % 86400;
  endtask

  task automatic prog(input int idx, input int h, input int m, input bit a);
    bus.wr_en = 1'b1; bus.wr_idx = IW'(idx); bus.wr_hr = 5'(h);
    bus.wr_min = 6'(m); bus.wr_arm = a;
    cyc();
  endtask

  task automatic goto_time(input int h, input int m, input int s);
    tod = h * 3600 + m * 60 + s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL reset_ringing got=%b exp=0000", ringing); end
    n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL reset_buzzer got=%b exp=0", buzzer); end
    n_cmp++; if (active_idx !== 2'd0) begin n_err++; $display("FAIL reset_active_idx got=%0d exp=0", active_idx); end
  endtask

  task automatic test_basic_ring();
    prog(0, 7, 30, 1'b1);
    goto_time(7, 29, 59);
    tick_once();
    n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL early_ring got=%b exp=0000", ringing); end
    tick_once();
    n_cmp++; if (ringing[0] !== 1'b1) begin n_err++; $display("FAIL basic_ring0 got=%b exp=1", ringing[0]); end
    n_cmp++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL basic_buzzer got=%b exp=1", buzzer); end
    n_cmp++; if (active_idx !== 2'd0) begin n_err++; $display("FAIL basic_idx got=%0d exp=0", active_idx); end
    for (int k = 1; k <= 60; k++) begin
      tick_once();
      n_cmp++;
      if (ringing[0] !== (k < 60)) begin
        n_err++; $display("FAIL auto_off_tick%0d got=%b exp=%b", k, ringing[0], (k < 60));
      end
    end
    n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL auto_off_buzzer got=%b exp=0", buzzer); end
  endtask

  task automatic test_dismiss_no_retrigger();
    goto_time(7, 29, 59);
    tick_once();
    tick_once();
    for (int k = 0; k < 4; k++) tick_once();
    dismiss = 1'b1;
    cyc();
    n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL dismiss_ring got=%b exp=0000", ringing); end
    for (int k = 0; k < 55; k++) begin
      tick_once();
      n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL retrigger_%0d got=%b exp=0000", k, ringing); end
    end
  endtask

  task automatic test_snooze();
    logic expv;
    prog(1, 8, 0, 1'b1);
    goto_time(7, 59, 59);
    tick_once();
    tick_once();
    n_cmp++; if (ringing !== 4'b0010) begin n_err++; $display("FAIL snooze_pre got=%b exp=0010", ringing); end
    snooze = 1'b1;
    cyc();
    expv = SNZ ? 1'b0 : 1'b1;
    n_cmp++; if (ringing[1] !== expv) begin n_err++; $display("FAIL snooze_pulse got=%b exp=%b", ringing[1], expv); end
    for (int k = 1; k <= SM * 60; k++) begin
      tick_once();
      n_cmp++; if (ringing !== exp_ring()) begin n_err++; $display("FAIL snooze_tick%0d got=%b exp=%b", k, ringing, exp_ring()); end
    end
    expv = SNZ ? 1'b1 : 1'b0;
    n_cmp++; if (ringing[1] !== expv) begin n_err++; $display("FAIL snooze_rering got=%b exp=%b", ringing[1], expv); end
    dismiss = 1'b1;
    cyc();
    n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL snooze_dismiss got=%b exp=0000", ringing); end
  endtask

  task automatic test_multi();
    prog(0, 0, 0, 1'b0);
    prog(2, 0, 0, 1'b0);
    prog(1, 6, 0, 1'b1);
    prog(3, 6, 0, 1'b1);
    goto_time(5, 59, 59);
    tick_once();
    tick_once();
    n_cmp++; if (ringing !== 4'b1010) begin n_err++; $display("FAIL multi_ring got=%b exp=1010", ringing); end
    n_cmp++; if (active_idx !== 2'd1) begin n_err++; $display("FAIL multi_idx got=%0d exp=1", active_idx); end
    dismiss = 1'b1;
    cyc();
    n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL multi_dismiss got=%b exp=0000", ringing); end
    n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL multi_buzzer got=%b exp=0", buzzer); end
  endtask

  task automatic test_write_while_ringing();
    prog(2, 9, 15, 1'b1);
    goto_time(9, 14, 59);
    tick_once();
    tick_once();
    n_cmp++; if (ringing[2] !== 1'b1) begin n_err++; $display("FAIL wr_pre got=%b exp=1", ringing[2]); end
    prog(2, 25, 0, 1'b1);
    n_cmp++; if (ringing[2] !== 1'b1) begin n_err++; $display("FAIL wr_bad_hr got=%b exp=1", ringing[2]); end
    prog(2, 9, 60, 1'b1);
    n_cmp++; if (ringing[2] !== 1'b1) begin n_err++; $display("FAIL wr_bad_min got=%b exp=1", ringing[2]); end
    prog(2, 10, 0, 1'b1);
    n_cmp++; if (ringing[2] !== 1'b0) begin n_err++; $display("FAIL wr_valid got=%b exp=0", ringing[2]); end
    n_cmp++; if (active_idx !== 2'd0) begin n_err++; $display("FAIL wr_idx got=%0d exp=0", active_idx); end
  endtask

  task automatic test_back_to_back();
    prog(0, 12, 0, 1'b1);
    prog(1, 12, 1, 1'b1);
    goto_time(11, 59, 59);
    tick_once();
    tick_once();
    for (int k = 1; k < 60; k++) tick_once();
    n_cmp++; if (ringing !== 4'b0001) begin n_err++; $display("FAIL b2b_first got=%b exp=0001", ringing); end
    tick_once();
    n_cmp++; if (ringing !== 4'b0010) begin n_err++; $display("FAIL b2b_handover got=%b exp=0010", ringing); end
    n_cmp++; if (active_idx !== 2'd1) begin n_err++; $display("FAIL b2b_idx got=%0d exp=1", active_idx); end
    dismiss = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid();
    prog(0, 11, 0, 1'b1);
    goto_time(10, 59, 59);
    tick_once();
    tick_once();
    snooze = 1'b1;
    cyc();
    tick_once();
    rst = 1'b1;
    cyc();
    n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL rstmid_ring got=%b exp=0000", ringing); end
    n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL rstmid_buzzer got=%b exp=0", buzzer); end
    goto_time(10, 59, 59);
    tick_once();
    tick_once();
    n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL rstmid_disarmed got=%b exp=0000", ringing); end
    for (int k = 0; k < 400; k++) begin
      tick_once();
      n_cmp++; if (ringing !== 4'b0000) begin n_err++; $display("FAIL rstmid_pending%0d got=%b exp=0000", k, ringing); end
    end
  endtask

  task automatic test_random();
    int r, t, h, m;
    rst = 1'b1;
    cyc();
    tod = 3600 * 13;
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        t = (tod + int'($urandom_range(0, 150))) % 86400;
        h = t / 3600; m = (t / 60) % 60;
        if ($urandom_range(0, 9) == 0) h = int'($urandom_range(24, 31));
        if ($urandom_range(0, 9) == 0) m = int'($urandom_range(60, 63));
        bus.wr_en = 1'b1; bus.wr_idx = IW'($urandom_range(0, NA - 1));
        bus.wr_hr = 5'(h); bus.wr_min = 6'(m); bus.wr_arm = ($urandom_range(0, 3) != 0);
      end else if (r < 8) begin
        dismiss = 1'b1;
      end else if (r < 12) begin
        snooze = 1'b1;
      end else if (r == 12 && $urandom_range(0, 4) == 0) begin
        rst = 1'b1;
      end
      if ($urandom_range(0, 9) < 8) begin
        tick_once();
      end else begin
        cyc();
      end
      n_cmp++; if (ringing !== exp_ring()) begin n_err++; $display("FAIL rand_ring@%0d got=%b exp=%b", n, ringing, exp_ring()); end
      n_cmp++; if (buzzer !== (|exp_ring())) begin n_err++; $display("FAIL rand_buzzer@%0d got=%b exp=%b", n, buzzer, |exp_ring()); end
      n_cmp++; if (active_idx !== exp_idx()) begin n_err++; $display("FAIL rand_idx@%0d got=%0d exp=%0d", n, active_idx, exp_idx()); end
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_hr = '0; bus.wr_min = '0; bus.wr_arm = 1'b0;
    set_time();
    test_reset();
    test_basic_ring();
    test_dismiss_no_retrigger();
    test_snooze();
    test_multi();
    test_write_while_ringing();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
